seq_multiplier: RTL



---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_step.sv | 21 ++
 rtl/seq_multiplier.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential shift-and-add multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_WIDTH_DEFAULT = 8;

  // Counter must reach WIDTH-1; one spare bit keeps the compare unambiguous.
  function automatic int mul_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mul_step.sv
// rtl/mul_step.sv - one shift-and-add iteration: conditionally add the shifted multiplicand
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic               mplier_lsb,
  output logic [2*WIDTH-1:0] acc_next
);

  // The product of two WIDTH-bit values fits in 2*WIDTH bits, so truncation is lossless.
  always_comb begin
    acc_next = acc;
    if (mplier_lsb) begin
      acc_next = acc + mcand;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - WIDTH-cycle shift-and-add multiplier with start/busy/done handshake
// Optional two's-complement operands when SEQ_MULTIPLIER_SIGNED_EN is defined.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] MUL_Out
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = mul_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_e       state;
  mul_state_e       state_next;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_step;

  // DONE accepts a new start just like IDLE so back-to-back operations lose no cycle.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_step = (state == CALC) && (cnt == LAST_CNT);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  logic neg;
  logic neg_in;

  // Negating the most-negative value wraps to 2^(WIDTH-1), its correct unsigned magnitude.
  assign a_lat   = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_lat   = B[WIDTH-1] ? (~B + 1'b1) : B;
  assign neg_in  = A[WIDTH-1] ^ B[WIDTH-1];
  assign product = neg ? (~acc_next + 1'b1) : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= neg_in;
    end
  end
`else
  assign a_lat   = A;
  assign b_lat   = B;
  assign product = acc_next;
`endif

  mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .mplier_lsb(mplier[0]),
    .acc_next  (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      MUL_Out <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_lat};
      mplier <= b_lat;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last_step) begin
        MUL_Out <= product;
      end
    end
  end

endmodule
